sd_spi_response_rx: RTL and testbench

// Receive side of the SD-card SPI link. Slow_clock_signal drives SCLK toward the card; this block

---
 rtl/sd_spi_response_rx.sv | 149 ++++++++++++++
 tb/tb_sd_spi_response_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_response_rx.sv
// SD-card SPI response receiver: samples MISO on SCLK rising edges, hunts for the R1 start bit,
// then captures R1 plus 0-4 trailing payload bytes, reporting valid or timeout.
module sd_spi_response_rx #(
  parameter int unsigned NCR_MAX = 8
) (
  input  logic        current_clock_signal,
  input  logic        reset,
  input  logic        init_completed,
  input  logic        sclk_in,
  input  logic        miso,
  input  logic        start,
  input  logic [2:0]  resp_len,
  output logic        busy,
  output logic        resp_valid,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] resp_data
);

  localparam int unsigned HuntMax = 8 * NCR_MAX;
  localparam int unsigned HuntW   = $clog2(HuntMax + 1);

  typedef enum logic [1:0] {StIdle, StHunt, StR1, StData} state_e;

  state_e             state_q, state_d;
  logic [2:0]         len_q, len_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [HuntW-1:0]   hunt_cnt_q, hunt_cnt_d;
  logic [7:0]         r1_q, r1_d;
  logic [31:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               sclk_q;
  logic               miso_meta_q, miso_s_q;
  logic               rise;

  assign rise = sclk_in & ~sclk_q;

  always_ff @(posedge current_clock_signal or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= 3'd0;
      bit_cnt_q   <= 6'd0;
      hunt_cnt_q  <= '0;
      r1_q        <= 8'hFF;
      data_q      <= 32'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      sclk_q      <= 1'b0;
      miso_meta_q <= 1'b1;
      miso_s_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      hunt_cnt_q  <= hunt_cnt_d;
      r1_q        <= r1_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      sclk_q      <= sclk_in;
      miso_meta_q <= miso;
      miso_s_q    <= miso_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    hunt_cnt_d = hunt_cnt_q;
    r1_d       = r1_q;
    data_d     = data_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Any rise coinciding with the accepted start is deliberately dropped.
        if (start && init_completed) begin
          state_d    = StHunt;
          len_d      = (resp_len > 3'd4) ? 3'd4 : resp_len;
          r1_d       = 8'hFF;
          data_d     = 32'd0;
          bit_cnt_d  = 6'd0;
          hunt_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      StHunt: begin
        if (rise) begin
          if (!miso_s_q) begin
            r1_d      = {r1_q[6:0], 1'b0};
            bit_cnt_d = 6'd1;
            state_d   = StR1;
          end else if (hunt_cnt_q == HuntW'(HuntMax - 1)) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + HuntW'(1);
          end
        end
      end
      StR1: begin
        if (rise) begin
          r1_d = {r1_q[6:0], miso_s_q};
          if (bit_cnt_q == 6'd7) begin
            bit_cnt_d = 6'd0;
            if (len_q == 3'd0) begin
              state_d = StIdle;
              valid_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = StData;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StData: begin
        if (rise) begin
          data_d = {data_q[30:0], miso_s_q};
          if ((bit_cnt_q + 6'd1) == {len_q, 3'b000}) begin
            bit_cnt_d = 6'd0;
            state_d   = StIdle;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign timeout    = timeout_q;
  assign r1         = r1_q;
  assign resp_data  = data_q;

endmodule

// File: tb/tb_sd_spi_response_rx.sv
// Self-checking bench for sd_spi_response_rx: table-driven directed responses, hand-written
// corner sequences and randomized responses checked against a bit-stream reference model.
module tb_sd_spi_response_rx;

  logic        clk = 1'b0;
  logic        reset, init_completed, sclk_in, miso, start;
  logic [2:0]  resp_len;
  logic        busy, resp_valid, timeout;
  logic [7:0]  r1;
  logic [31:0] resp_data;

  sd_spi_response_rx #(.NCR_MAX(8)) dut (
    .current_clock_signal(clk),
    .reset               (reset),
    .init_completed      (init_completed),
    .sclk_in             (sclk_in),
    .miso                (miso),
    .start               (start),
    .resp_len            (resp_len),
    .busy                (busy),
    .resp_valid          (resp_valid),
    .timeout             (timeout),
    .r1                  (r1),
    .resp_data           (resp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [79:0] bytes;   // MSB-first byte stream, left-aligned
    logic [3:0]  nbytes;
    logic [2:0]  len;
    logic [7:0]  mid;     // bit index at which a stray start is pulsed; 255 = none
    logic        exp_to;
    logic [7:0]  exp_r1;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  bit   stim_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_bit, valid_seen, timeout_seen, pulse_bit, mid_start_at;
  logic pulse_first, pulse_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic first);
    @(posedge clk);
    #1;
    if (resp_valid || timeout) begin
      if (resp_valid) valid_seen++;
      if (timeout) timeout_seen++;
      pulse_bit   = cur_bit;
      pulse_first = first;
      pulse_busy  = busy;
    end
  endtask

  // One SCLK period: MISO changes with the falling edge, card sampled on the rise.
  task automatic send_bit(input bit b);
    miso    = b;
    sclk_in = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 0 && cur_bit == mid_start_at) begin
        start    = 1'b1;
        resp_len = 3'd0;
      end
      cyc(1'b0);
      start = 1'b0;
    end
    sclk_in = 1'b1;
    for (int c = 0; c < 15; c++) cyc(c == 0);
    cur_bit++;
  endtask

  // Reference: first 0 within 64 sampled bits opens R1; payload follows directly.
  task automatic model(input logic [2:0] len, output logic to, output logic [7:0] er1,
                       output logic [31:0] ed, output int idx);
    int eff   = (len > 3'd4) ? 4 : int'(len);
    int first = -1;
    for (int i = 0; i < 64 && i < stim_q.size(); i++)
      if (first < 0 && stim_q[i] == 1'b0) first = i;
    er1 = 8'hFF;
    ed  = 32'd0;
    if (first < 0) begin
      to  = 1'b1;
      idx = 63;
    end else begin
      to  = 1'b0;
      er1 = 8'd0;
      for (int k = 0; k < 8; k++) er1 = {er1[6:0], stim_q[first + k]};
      for (int k = 0; k < 8 * eff; k++) ed = {ed[30:0], stim_q[first + 8 + k]};
      idx = first + 7 + 8 * eff;
    end
  endtask

  task automatic run_txn(input logic [2:0] len, input int mid, input logic exp_to,
                         input logic [7:0] exp_r1, input logic [31:0] exp_data, input int exp_idx);
    valid_seen   = 0;
    timeout_seen = 0;
    pulse_bit    = -1;
    pulse_first  = 1'b0;
    pulse_busy   = 1'b1;
    mid_start_at = mid;
    resp_len     = len;
    start        = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    cur_bit = 0;
    for (int i = 0; i < stim_q.size(); i++) send_bit(stim_q[i]);
    check("valid_count", valid_seen, exp_to ? 32'd0 : 32'd1);
    check("timeout_count", timeout_seen, exp_to ? 32'd1 : 32'd0);
    check("pulse_bit_index", pulse_bit, exp_idx);
    check("pulse_after_rise", {31'd0, pulse_first}, 32'd1);
    check("busy_low_at_pulse", {31'd0, pulse_busy}, 32'd0);
    check("r1", {24'd0, r1}, {24'd0, exp_r1});
    check("resp_data", resp_data, exp_data);
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic load_vec(input vec_t v);
    logic [7:0] b;
    stim_q.delete();
    for (int j = 0; j < int'(v.nbytes); j++) begin
      b = v.bytes[79 - 8 * j -: 8];
      for (int k = 7; k >= 0; k--) stim_q.push_back(b[k]);
    end
    for (int k = 0; k < 8; k++) stim_q.push_back(1'b1);
  endtask

  initial begin
    logic        m_to;
    logic [7:0]  m_r1, b;
    logic [31:0] m_data;
    int          m_idx, lead;
    logic [2:0]  rlen;

    vecs[0] = '{bytes: {24'hFFFF01, 56'd0}, nbytes: 4'd3, len: 3'd0, mid: 8'd255,
                exp_to: 1'b0, exp_r1: 8'h01, exp_data: 32'h0};
    vecs[1] = '{bytes: {48'hFF010000_01AA, 32'd0}, nbytes: 4'd6, len: 3'd4, mid: 8'd255,
                exp_to: 1'b0, exp_r1: 8'h01, exp_data: 32'h000001AA};
    vecs[2] = '{bytes: {64'hFFFFFFFF_FFFFFFFF, 16'd0}, nbytes: 4'd8, len: 3'd0, mid: 8'd255,
                exp_to: 1'b1, exp_r1: 8'hFF, exp_data: 32'h0};
    vecs[3] = '{bytes: {40'h00DEADBEEF, 40'd0}, nbytes: 4'd5, len: 3'd7, mid: 8'd255,
                exp_to: 1'b0, exp_r1: 8'h00, exp_data: 32'hDEADBEEF};
    vecs[4] = '{bytes: {16'hF03C, 64'd0}, nbytes: 4'd2, len: 3'd0, mid: 8'd255,
                exp_to: 1'b0, exp_r1: 8'h03, exp_data: 32'h0};
    vecs[5] = '{bytes: {24'hFF015A, 56'd0}, nbytes: 4'd3, len: 3'd1, mid: 8'd12,
                exp_to: 1'b0, exp_r1: 8'h01, exp_data: 32'h0000005A};

    reset = 1'b1; init_completed = 1'b1; sclk_in = 1'b0; miso = 1'b1; start = 1'b0;
    resp_len = 3'd0; cur_bit = 0; mid_start_at = -1;
    repeat (3) cyc(1'b0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_r1", {24'd0, r1}, 32'hFF);
    check("reset_resp_data", resp_data, 32'd0);
    reset = 1'b0;
    cyc(1'b0);

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      model(vecs[v].len, m_to, m_r1, m_data, m_idx);
      run_txn(vecs[v].len, (vecs[v].mid == 8'd255) ? -1 : int'(vecs[v].mid),
              vecs[v].exp_to, vecs[v].exp_r1, vecs[v].exp_data, m_idx);
    end

    // Start while init is incomplete must be ignored entirely.
    init_completed = 1'b0;
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    repeat (4) cyc(1'b0);
    check("no_start_without_init", {31'd0, busy}, 32'd0);
    check("r1_held_without_init", {24'd0, r1}, {24'd0, vecs[5].exp_r1});
    init_completed = 1'b1;

    // Reset in the middle of the payload, after 12 data bits.
    stim_q.delete();
    b = 8'h01;
    for (int k = 7; k >= 0; k--) stim_q.push_back(b[k]);
    for (int k = 31; k >= 0; k--) stim_q.push_back(m_data[k] ^ 1'b1);
    mid_start_at = -1;
    resp_len = 3'd4;
    start = 1'b1;
    cyc(1'b0);
    start = 1'b0;
    cur_bit = 0;
    for (int i = 0; i < 20; i++) send_bit(stim_q[i]);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    cyc(1'b0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_r1", {24'd0, r1}, 32'hFF);
    check("mid_reset_resp_data", resp_data, 32'd0);
    reset = 1'b0;
    cyc(1'b0);

    load_vec(vecs[1]);
    model(vecs[1].len, m_to, m_r1, m_data, m_idx);
    run_txn(vecs[1].len, -1, vecs[1].exp_to, vecs[1].exp_r1, vecs[1].exp_data, m_idx);

    for (int t = 0; t < 12; t++) begin
      stim_q.delete();
      lead = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 70))
                                         : int'($urandom_range(0, 20));
      for (int k = 0; k < lead; k++) stim_q.push_back(1'b1);
      stim_q.push_back(1'b0);
      for (int k = 0; k < 39; k++) stim_q.push_back(bit'($urandom_range(0, 1)));
      for (int k = 0; k < 8; k++) stim_q.push_back(1'b1);
      rlen = 3'($urandom_range(0, 7));
      model(rlen, m_to, m_r1, m_data, m_idx);
      run_txn(rlen, -1, m_to, m_r1, m_data, m_idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
